// File: rtl/cnu_minsum_if.sv
// cnu_minsum_if: row stream into, and check-to-variable messages out of, the check node unit
interface cnu_minsum_if #(
  parameter int DEG           = 6,
  parameter int MESSAGE_WIDTH = 5,
  parameter int ROW_WIDTH     = 5
);
  logic                               enable;
  logic                               in_valid;
  logic [DEG*(MESSAGE_WIDTH+1)-1:0]   msg_in;
  logic                               out_valid;
  logic [DEG*MESSAGE_WIDTH-1:0]       msg_out;
  logic [ROW_WIDTH-1:0]               out_row;
  logic                               frame_done;

  // The PE side streams rows in and collects results
  modport master (
    output enable, in_valid, msg_in,
    input  out_valid, msg_out, out_row, frame_done
  );

  // The check node unit itself
  modport slave (
    input  enable, in_valid, msg_in,
    output out_valid, msg_out, out_row, frame_done
  );
endinterface

// File: rtl/cnu_minsum.sv
// cnu_minsum: six-stage offset min-sum check node unit.
// The compare tree (pairs 01/23/45, then two merges) is laid out for six lanes.
module cnu_minsum #(
  parameter int DEG           = 6,
  parameter int MESSAGE_WIDTH = 5,
  parameter int L             = 32,
  parameter int OFFSET        = 1,
  parameter int ROW_WIDTH     = 5
) (
  input  logic        clk,
  input  logic        reset,
  cnu_minsum_if.slave bus
);
  localparam int MW = MESSAGE_WIDTH;
  localparam int LW = MW + 1;
  localparam int OW = MW - 1;
  localparam logic [MW-1:0]        SAT      = MW'((1 << OW) - 1);
  localparam logic [MW-1:0]        OFF      = MW'(OFFSET);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(L - 1);

  // Partial min-sum result over a group of lanes; lower lane indices win ties
  typedef struct packed {
    logic [MW-1:0] min1;
    logic [MW-1:0] min2;
    logic [2:0]    idx;
    logic          sgn;
  } part_t;

  function automatic part_t pair_cmp(logic [MW-1:0] ma, logic [MW-1:0] mb,
                                     logic sa, logic sb, logic [2:0] ia);
    part_t p;
    p.sgn = sa ^ sb;
    if (ma <= mb) begin
      p.min1 = ma;
      p.min2 = mb;
      p.idx  = ia;
    end else begin
      p.min1 = mb;
      p.min2 = ma;
      p.idx  = ia + 3'd1;
    end
    return p;
  endfunction

  // Group a always holds the lower lane indices, so it wins equal minima
  function automatic part_t merge(part_t a, part_t b);
    part_t p;
    p.sgn = a.sgn ^ b.sgn;
    if (a.min1 <= b.min1) begin
      p.min1 = a.min1;
      p.idx  = a.idx;
      p.min2 = (a.min2 <= b.min1) ? a.min2 : b.min1;
    end else begin
      p.min1 = b.min1;
      p.idx  = b.idx;
      p.min2 = (a.min1 <= b.min2) ? a.min1 : b.min2;
    end
    return p;
  endfunction

  function automatic logic [OW-1:0] offset_sat(logic [MW-1:0] m);
    logic [MW-1:0] r;
    r = (m > OFF) ? m - OFF : '0;
    if (r > SAT) r = SAT;
    return r[OW-1:0];
  endfunction

  logic                   accept;
  logic [ROW_WIDTH-1:0]   in_row;
  logic [DEG-1:0]         in_sign;
  logic [DEG-1:0][MW-1:0] in_mag;

  logic                   s1_valid;
  logic [ROW_WIDTH-1:0]   s1_row;
  logic [DEG-1:0]         s1_sign;
  logic [DEG-1:0][MW-1:0] s1_mag;

  logic                   s2_valid;
  logic [ROW_WIDTH-1:0]   s2_row;
  logic [DEG-1:0]         s2_sign;
  part_t [2:0]            s2_pair;

  logic                   s3_valid;
  logic [ROW_WIDTH-1:0]   s3_row;
  logic [DEG-1:0]         s3_sign;
  part_t                  s3_lo;
  part_t                  s3_hi;

  logic                   s4_valid;
  logic [ROW_WIDTH-1:0]   s4_row;
  logic [DEG-1:0]         s4_sign;
  part_t                  s4_all;

  logic                   s5_valid;
  logic [ROW_WIDTH-1:0]   s5_row;
  logic [DEG-1:0]         s5_sign;
  logic [OW-1:0]          s5_m1;
  logic [OW-1:0]          s5_m2;
  logic [2:0]             s5_idx;
  logic                   s5_tsign;

  logic                   s6_valid;
  logic [ROW_WIDTH-1:0]   s6_row;
  logic [DEG*MW-1:0]      s6_msg;
  logic [DEG*MW-1:0]      s6_next;
  logic [OW-1:0]          lane_mag;
  logic                   lane_sign;

  assign accept = bus.enable & bus.in_valid;

  // Split each incoming lane into its sign bit and unsigned magnitude
  always_comb begin
    in_mag  = '0;
    in_sign = '0;
    for (int i = 0; i < DEG; i++) begin
      in_mag[i]  = bus.msg_in[i*LW +: MW];
      in_sign[i] = bus.msg_in[i*LW + MW];
    end
  end

  // Row tag counter, wrapping after the last row of a pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_row <= '0;
    else if (accept) in_row <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
  end

  // S1: capture the row with its tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_row   <= '0;
      s1_sign  <= '0;
      s1_mag   <= '0;
    end else if (bus.enable) begin
      s1_valid <= bus.in_valid;
      s1_row   <= in_row;
      s1_sign  <= in_sign;
      s1_mag   <= in_mag;
    end
  end

  // S2: order each neighbouring lane pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_row   <= '0;
      s2_sign  <= '0;
      s2_pair  <= '0;
    end else if (bus.enable) begin
      s2_valid   <= s1_valid;
      s2_row     <= s1_row;
      s2_sign    <= s1_sign;
      s2_pair[0] <= pair_cmp(s1_mag[0], s1_mag[1], s1_sign[0], s1_sign[1], 3'd0);
      s2_pair[1] <= pair_cmp(s1_mag[2], s1_mag[3], s1_sign[2], s1_sign[3], 3'd2);
      s2_pair[2] <= pair_cmp(s1_mag[4], s1_mag[5], s1_sign[4], s1_sign[5], 3'd4);
    end
  end

  // S3: fold lanes 0-3 together, carry lanes 4-5 alongside
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_row   <= '0;
      s3_sign  <= '0;
      s3_lo    <= '0;
      s3_hi    <= '0;
    end else if (bus.enable) begin
      s3_valid <= s2_valid;
      s3_row   <= s2_row;
      s3_sign  <= s2_sign;
      s3_lo    <= merge(s2_pair[0], s2_pair[1]);
      s3_hi    <= s2_pair[2];
    end
  end

  // S4: global two smallest magnitudes, their position and the parity of all signs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s4_valid <= 1'b0;
      s4_row   <= '0;
      s4_sign  <= '0;
      s4_all   <= '0;
    end else if (bus.enable) begin
      s4_valid <= s3_valid;
      s4_row   <= s3_row;
      s4_sign  <= s3_sign;
      s4_all   <= merge(s3_lo, s3_hi);
    end
  end

  // S5: apply the offset without underflow, then clamp into the output magnitude range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s5_valid <= 1'b0;
      s5_row   <= '0;
      s5_sign  <= '0;
      s5_m1    <= '0;
      s5_m2    <= '0;
      s5_idx   <= '0;
      s5_tsign <= 1'b0;
    end else if (bus.enable) begin
      s5_valid <= s4_valid;
      s5_row   <= s4_row;
      s5_sign  <= s4_sign;
      s5_m1    <= offset_sat(s4_all.min1);
      s5_m2    <= offset_sat(s4_all.min2);
      s5_idx   <= s4_all.idx;
      s5_tsign <= s4_all.sgn;
    end
  end

  // Build outgoing lanes: the minimum lane gets min2, a zero magnitude never carries a sign
  always_comb begin
    s6_next   = '0;
    lane_mag  = '0;
    lane_sign = 1'b0;
    for (int i = 0; i < DEG; i++) begin
      lane_mag  = (3'(i) == s5_idx) ? s5_m2 : s5_m1;
      lane_sign = (lane_mag != '0) & (s5_tsign ^ s5_sign[i]);
      s6_next[i*MW +: MW] = {lane_sign, lane_mag};
    end
  end

  // S6: output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s6_valid <= 1'b0;
      s6_row   <= '0;
      s6_msg   <= '0;
    end else if (bus.enable) begin
      s6_valid <= s5_valid;
      s6_row   <= s5_row;
      s6_msg   <= s6_next;
    end
  end

  assign bus.out_valid  = s6_valid & bus.enable;
  assign bus.msg_out    = s6_msg;
  assign bus.out_row    = s6_row;
  assign bus.frame_done = s6_valid & bus.enable & (s6_row == LAST_ROW);
endmodule

// File: tb/tb_cnu_minsum.sv
// tb_cnu_minsum: randomized and directed checks of cnu_minsum against a row-level model
module tb_cnu_minsum;
  localparam int DEG = 6;
  localparam int MW  = 5;
  localparam int RW  = 5;
  localparam int L   = 32;

  typedef struct {
    int            due;
    int            row;
    logic [29:0]   msg;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   en_edges = 0;
  int   row_ctr = 0;
  exp_t q[$];
  logic        exp_have;
  logic        exp_valid;
  logic        exp_frame;
  logic [29:0] exp_msg;
  logic [4:0]  exp_row;

  cnu_minsum_if #(.DEG(DEG), .MESSAGE_WIDTH(MW), .ROW_WIDTH(RW)) bus ();

  cnu_minsum #(.DEG(DEG), .MESSAGE_WIDTH(MW), .L(L), .OFFSET(1), .ROW_WIDTH(RW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Check node rule from first principles: scan for the two smallest magnitudes
  function automatic logic [29:0] ref_row(input logic [35:0] row);
    int          mag[6];
    bit          sg[6];
    int          m1, m2, i1, om;
    bit          tot, s;
    logic [29:0] res;
    logic [4:0]  lane;
    m1 = 1000; m2 = 1000; i1 = 0; tot = 0; res = '0;
    for (int i = 0; i < 6; i++) begin
      mag[i] = int'(row[i*6 +: 5]);
      sg[i]  = row[i*6 + 5];
      tot    = tot ^ sg[i];
    end
    for (int i = 0; i < 6; i++) if (mag[i] < m1) begin m1 = mag[i]; i1 = i; end
    for (int i = 0; i < 6; i++) if (i != i1 && mag[i] < m2) m2 = mag[i];
    m1 = (m1 - 1 < 0) ? 0 : m1 - 1;
    m2 = (m2 - 1 < 0) ? 0 : m2 - 1;
    if (m1 > 15) m1 = 15;
    if (m2 > 15) m2 = 15;
    for (int i = 0; i < 6; i++) begin
      om   = (i == i1) ? m2 : m1;
      s    = (om == 0) ? 1'b0 : (tot ^ sg[i]);
      lane = {s, 4'(om)};
      res[i*5 +: 5] = lane;
    end
    return res;
  endfunction

  function automatic logic [35:0] pack_row(input logic [5:0][4:0] mags, input logic [5:0] signs);
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*6 +: 6] = {signs[i], mags[i]};
    return r;
  endfunction

  function automatic logic [35:0] rand_row();
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*6 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      r[i*6 + 5]  = 1'($urandom_range(0, 1));
    end
    return r;
  endfunction

  // Drive one clock of stimulus and advance the expectation queue
  task automatic tick(input logic en, input logic v, input logic [35:0] d);
    exp_t e;
    bus.enable   = en;
    bus.in_valid = v;
    bus.msg_in   = d;
    @(posedge clk);
    #1;
    if (en) begin
      en_edges++;
      if (v) begin
        e.due = en_edges + 5;
        e.row = row_ctr;
        e.msg = ref_row(d);
        q.push_back(e);
        row_ctr = (row_ctr + 1) % L;
      end
    end
    while (q.size() > 0 && q[0].due < en_edges) void'(q.pop_front());
    exp_have  = (q.size() > 0) && (q[0].due == en_edges);
    exp_valid = exp_have && en;
    exp_msg   = exp_have ? q[0].msg : '0;
    exp_row   = exp_have ? 5'(q[0].row) : '0;
    exp_frame = exp_valid && (q[0].row == L - 1);
  endtask

  task automatic assert_reset();
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    row_ctr = 0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] r;
    r = pack_row({5'd20, 5'd12, 5'd5, 5'd9, 5'd3, 5'd7}, 6'b010010);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", bus.out_valid); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame got %b want 0", bus.frame_done); end
    total++; if (bus.msg_out !== 30'h0) begin bad++; $display("[TB] FAIL reset_msg got %h want 0", bus.msg_out); end
    total++; if (bus.out_row !== 5'd0) begin bad++; $display("[TB] FAIL reset_row got %0d want 0", bus.out_row); end
    release_reset();
    tick(1'b1, 1'b1, r);
    tick(1'b1, 1'b1, r);
    for (int k = 3; k <= 7; k++) tick(1'b1, 1'b0, '0);
    total++; if (bus.out_valid !== 1'b1 || bus.out_row !== 5'd1) begin bad++; $display("[TB] FAIL pre_reset_out got v=%b row=%0d want v=1 row=1", bus.out_valid, bus.out_row); end
    assert_reset();
    total++; if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_valid got v=%b f=%b want 0 0", bus.out_valid, bus.frame_done); end
    total++; if (bus.msg_out !== 30'h0 || bus.out_row !== 5'd0) begin bad++; $display("[TB] FAIL async_reset_data got msg=%h row=%0d want 0 0", bus.msg_out, bus.out_row); end
    release_reset();
    tick(1'b1, 1'b1, r);
    for (int k = 2; k <= 10; k++) begin
      tick(1'b1, 1'b0, '0);
      total++; if (bus.out_valid !== (k == 6)) begin bad++; $display("[TB] FAIL post_reset_valid k=%0d got %b want %b", k, bus.out_valid, (k == 6)); end
      if (k == 6) begin
        total++; if (bus.out_row !== 5'd0) begin bad++; $display("[TB] FAIL post_reset_row got %0d want 0", bus.out_row); end
        total++; if (bus.msg_out !== exp_msg) begin bad++; $display("[TB] FAIL post_reset_msg got %h want %h", bus.msg_out, exp_msg); end
      end
    end
  endtask

  task automatic test_basic();
    logic [35:0] r;
    logic [29:0] want;
    r    = pack_row({5'd20, 5'd12, 5'd5, 5'd9, 5'd3, 5'd7}, 6'b010010);
    want = {5'b00010, 5'b10010, 5'b00010, 5'b00010, 5'b10100, 5'b00010};
    for (int k = 1; k <= 9; k++) begin
      tick(1'b1, k == 1, (k == 1) ? r : 36'h0);
      total++; if (bus.out_valid !== (k == 6)) begin bad++; $display("[TB] FAIL basic_valid k=%0d got %b want %b", k, bus.out_valid, (k == 6)); end
      if (k == 6) begin
        total++; if (bus.msg_out !== want) begin bad++; $display("[TB] FAIL basic_msg got %h want %h", bus.msg_out, want); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [35:0] a, b;
    a = pack_row({6{5'd31}}, 6'b111111);
    b = pack_row({6{5'd0}}, 6'b111111);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b1, k <= 2, (k == 1) ? a : b);
      total++; if (bus.out_valid !== (k == 6 || k == 7)) begin bad++; $display("[TB] FAIL sat_valid k=%0d got %b", k, bus.out_valid); end
      if (k == 6) begin
        total++; if (bus.msg_out !== {6{5'b11111}}) begin bad++; $display("[TB] FAIL sat_max got %h want %h", bus.msg_out, {6{5'b11111}}); end
      end
      if (k == 7) begin
        total++; if (bus.msg_out !== 30'h0) begin bad++; $display("[TB] FAIL sat_zero got %h want 0", bus.msg_out); end
      end
    end
  endtask

  task automatic test_tie();
    logic [35:0] a, b;
    logic [29:0] want;
    a    = pack_row({5'd9, 5'd9, 5'd9, 5'd9, 5'd4, 5'd4}, 6'b000001);
    want = {5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b00011};
    b    = pack_row({5'd9, 5'd9, 5'd2, 5'd6, 5'd2, 5'd11}, 6'b101100);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b1, k <= 2, (k == 1) ? a : b);
      if (k == 6) begin
        total++; if (bus.out_valid !== 1'b1 || bus.msg_out !== want) begin bad++; $display("[TB] FAIL tie_const got v=%b %h want %h", bus.out_valid, bus.msg_out, want); end
      end
      if (k == 7) begin
        total++; if (bus.out_valid !== 1'b1 || bus.msg_out !== exp_msg) begin bad++; $display("[TB] FAIL tie_model got v=%b %h want %h", bus.out_valid, bus.msg_out, exp_msg); end
      end
    end
  endtask

  task automatic test_stream();
    int seen;
    int frames;
    logic [35:0] d;
    seen = 0;
    frames = 0;
    assert_reset();
    release_reset();
    for (int c = 0; c < 72; c++) begin
      d = (c < 64) ? rand_row() : 36'h0;
      tick(1'b1, c < 64, d);
      total++; if (bus.out_valid !== exp_valid) begin bad++; $display("[TB] FAIL stream_valid c=%0d got %b want %b", c, bus.out_valid, exp_valid); end
      total++; if (bus.frame_done !== exp_frame) begin bad++; $display("[TB] FAIL stream_frame c=%0d got %b want %b", c, bus.frame_done, exp_frame); end
      if (exp_have) begin
        total++; if (bus.msg_out !== exp_msg) begin bad++; $display("[TB] FAIL stream_msg c=%0d got %h want %h", c, bus.msg_out, exp_msg); end
      end
      if (bus.out_valid === 1'b1) begin
        total++; if (bus.out_row !== 5'(seen % L)) begin bad++; $display("[TB] FAIL stream_row c=%0d got %0d want %0d", c, bus.out_row, seen % L); end
        if (bus.frame_done === 1'b1) frames++;
        seen++;
      end
    end
    total++; if (seen != 64) begin bad++; $display("[TB] FAIL stream_count got %0d want 64", seen); end
    total++; if (frames != 2) begin bad++; $display("[TB] FAIL stream_frames got %0d want 2", frames); end
  endtask

  task automatic test_stall();
    int seen;
    logic en, v;
    assert_reset();
    release_reset();
    seen = 0;
    for (int c = 0; c < 42; c++) begin
      en = !(c >= 20 && c < 23);
      v  = (c < 34) && (c != 10);
      tick(en, v, rand_row());
      total++; if (bus.out_valid !== exp_valid) begin bad++; $display("[TB] FAIL stall_valid c=%0d got %b want %b", c, bus.out_valid, exp_valid); end
      if (exp_have) begin
        total++; if (bus.msg_out !== exp_msg || bus.out_row !== exp_row) begin bad++; $display("[TB] FAIL stall_data c=%0d got %h/%0d want %h/%0d", c, bus.msg_out, bus.out_row, exp_msg, exp_row); end
      end
      if (c == 27) begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_row !== 5'd18) begin bad++; $display("[TB] FAIL stall_latency got v=%b row=%0d want v=1 row=18", bus.out_valid, bus.out_row); end
      end
      if (bus.out_valid === 1'b1) seen++;
    end
    total++; if (seen != 30) begin bad++; $display("[TB] FAIL stall_count got %0d want 30", seen); end
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.in_valid = 1'b0;
    bus.msg_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] starting");
    test_reset();
    test_basic();
    test_saturation();
    test_tie();
    test_stream();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnu_minsum.md
# cnu_minsum

Pipelined offset min-sum check node unit that consumes the per-row variable-to-check messages streamed out of the PE memory blocks during the CNU phase. It returns check-to-variable messages in the format the PE blocks write back into their extrinsic RAMs. One check row is accepted per clock. Results appear a fixed six clocks later, matching the decoder's CNU_DELAY. A row counter tags every result and flags the last row of each sub-matrix pass.

## Interface
Parameters:
- DEG, 6, check node degree: number of input/output lanes, one per PE column.
- MESSAGE_WIDTH, 5, width of an output message; each input lane is MESSAGE_WIDTH+1 bits.
- L, 32, rows per pass; the row counter wraps at L-1.
- OFFSET, 1, offset subtracted from the minimum magnitudes.
- ROW_WIDTH, 5, row tag width; must satisfy 2^ROW_WIDTH >= L.

Ports:
- clk  in  1  decoder clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  pipeline advance; 0 freezes every stage.
- in_valid  in  1  msg_in carries a row this cycle.
- msg_in  in  DEG*(MESSAGE_WIDTH+1)  lane i occupies bits [(i+1)*(MESSAGE_WIDTH+1)-1 : i*(MESSAGE_WIDTH+1)], lane 0 at the LSBs. Each lane is sign-magnitude: MSB is the sign, low MESSAGE_WIDTH bits are the magnitude.
- out_valid  out  1  msg_out and out_row are valid this cycle.
- msg_out  out  DEG*MESSAGE_WIDTH  same lane order; each lane is sign-magnitude with MSB as sign and MESSAGE_WIDTH-1 magnitude bits.
- out_row  out  ROW_WIDTH  row index of msg_out.
- frame_done  out  1  pulses with the result for row L-1.

## Operation
- Accept: a row is accepted on a rising edge where enable=1 and in_valid=1. When enable=0, in_valid is ignored.
- Row tag: in_row counter starts at 0 and increments on each accepted row. After L-1 it wraps to 0. The tag travels down the pipeline with its row.
- Six pipeline stages, each with its own valid bit:
  - S1: register the lanes; split sign and magnitude.
  - S2: compare pairs (0,1), (2,3), (4,5). For each pair produce min1, min2, idx1 and the XOR of the two signs.
  - S3: merge pair01 with pair23.
  - S4: merge in pair45. Result is global min1, min2, idx1, and total sign.
  - S5: m1' = max(min1-OFFSET, 0) and m2' = max(min2-OFFSET, 0). Saturate both to 2^(MESSAGE_WIDTH-1)-1.
  - S6 (output register): lane i magnitude is m2' if i==idx1, otherwise m1'. Lane i sign is total_sign XOR sign_i. If the lane magnitude is 0, the sign is forced to 0.
- Ties: on equal magnitudes the lower lane index becomes idx1, and min2 then equals min1.
- Width rules: magnitude compare is unsigned on MESSAGE_WIDTH bits. Subtraction must not underflow. Saturation is applied after the offset is subtracted.
- frame_done = out_valid AND (out_row == L-1).

## Timing
- Reset: asynchronous and immediate. All stage valids, out_valid, frame_done, msg_out, out_row and in_row go to 0. Reset must deassert synchronously to clk.
- Latency: a row accepted at enabled edge N appears at outputs after enabled edge N+5, i.e. it is visible during the 6th cycle counting the accept cycle. Frozen cycles are not counted.
- Throughput: one row per clock, with no bubbles inserted.
- enable=0:
  - All stage registers, valids and in_row hold their values.
  - out_valid and frame_done are gated to 0.
  - msg_out and out_row hold their values.
  - On return to enable=1, the pipeline resumes with no loss or duplication.
- Gaps in in_valid propagate as out_valid=0 bubbles exactly six enabled cycles later.
- in_valid together with the wrap to row 0: the counter wraps on the same edge. No stall occurs.
- Reset during streaming discards all in-flight rows. The first row accepted afterwards is tagged row 0.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> out_valid=0, frame_done=0, msg_out=0 and out_row=0 immediately. The next accepted row emerges with out_row=0.
- Basic row: lane magnitudes {7,3,9,5,12,20} with signs {0,1,0,0,1,0}, single in_valid pulse -> exactly 6 cycles later out_valid=1 for one cycle. Expected lanes: {+2, -4, +2, +2, -2, +2}, where lane 1 receives min2'.
- Saturation and sign: all magnitudes 31, all signs 1 -> every lane is -15, i.e. 5'b11111 per lane. Then all magnitudes 0 with signs 1 -> every lane is 5'b00000 (no negative zero).
- Tie: lane magnitudes {4,4,9,9,9,9} -> lane 0 is 3 (min2' = 3), all other lanes are 3, and idx1 = 0 is verified via lane-specific signs.
- Stream: 64 back-to-back rows of random stimulus checked against a reference model -> 64 consecutive out_valid cycles with out_row 0..31,0..31. frame_done is high only at the two row-31 outputs.
- Stall: deassert enable for 3 cycles in the middle of the stream -> out_valid is 0 during the stall, outputs are held, and no row is lost or repeated. Total latency of affected rows is 6+3 clocks.
